// File: rtl/booth_controller.sv
// Sequencing FSM for the 16-bit Booth multiplier: takes operands over valid/ready,
// strobes the datapath through load/iterate/store, and guards the iterate phase with a watchdog.
module booth_controller #(
    parameter int WIDTH_CO = 5,
    parameter int TIMEOUT  = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    input  logic count,
    output logic load,
    output logic load_pp,
    output logic enable_a,
    output logic enable_b,
    output logic enable_pp,
    output logic load_p,
    output logic busy,
    output logic error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MULT  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [WIDTH_CO-1:0] LAST_ITER = WIDTH_CO'(TIMEOUT - 1);

    state_t              state;
    logic [WIDTH_CO-1:0] iter_cnt;

    // NOTE: state is updated with non-blocking assignments only, so every branch
    // below reads the pre-edge value of state and iter_cnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= LOAD;
                        iter_cnt <= '0;
                        error    <= 1'b0;
                    end
                end
                LOAD: state <= MULT;
                MULT: begin
                    iter_cnt <= iter_cnt + 1'b1;
                    if (count) begin
                        state <= STORE;
                    end else if (iter_cnt == LAST_ITER) begin
                        state <= IDLE;
                        error <= 1'b1;
                    end
                end
                STORE: state <= DONE;
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are pure decodes of the state register, so reset forces them low at once.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign load      = (state == LOAD);
    assign load_pp   = (state == LOAD);
    assign enable_a  = (state == LOAD);
    assign enable_b  = (state == LOAD);
    assign load_p    = (state == STORE);
    assign out_valid = (state == DONE);
    // NOTE: enable_pp must see count in the same cycle; registering it would
    // let one extra Booth step slip through when the flag arrives.
    assign enable_pp = (state == MULT) && !count;

endmodule

// File: tb/tb_booth_controller.sv
// Randomized self-checking bench for booth_controller; a behavioural Booth datapath
// supplies count and the product, and expectations come from plain signed arithmetic.
module tb_booth_controller;

    localparam int STEPS     = 16;
    localparam int TIMEOUT   = 24;
    localparam int LATENCY   = STEPS + 1 + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic stuck0 = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;

    logic in_ready, out_valid, count, load, load_pp, enable_a, enable_b;
    logic enable_pp, load_p, busy, error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_controller #(.WIDTH_CO(5), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .load      (load),
        .load_pp   (load_pp),
        .enable_a  (enable_a),
        .enable_b  (enable_b),
        .enable_pp (enable_pp),
        .load_p    (load_p),
        .busy      (busy),
        .error     (error)
    );

    // Behavioural radix-2 Booth datapath driven by the controller's strobes.
    logic [16:0] dp_acc, dp_m;
    logic [15:0] dp_q;
    logic        dp_qm1, dp_count;
    logic [4:0]  dp_cnt;
    logic [31:0] dp_product;

    assign count = dp_count & ~stuck0;

    function automatic logic [33:0] booth_step(input logic [16:0] acc, input logic [15:0] q,
                                               input logic qm1, input logic [16:0] m);
        logic [16:0] s;
        case ({q[0], qm1})
            2'b01:   s = acc + m;
            2'b10:   s = acc - m;
            default: s = acc;
        endcase
        return {s[16], s[16:1], s[0], q[15:1], q[0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_acc <= '0; dp_m <= '0; dp_q <= '0; dp_qm1 <= 1'b0;
            dp_cnt <= '0; dp_count <= 1'b0; dp_product <= '0;
        end else begin
            if (enable_a) dp_m <= {op_a[15], op_a};
            if (load) begin
                dp_cnt   <= '0;
                dp_count <= 1'b0;
            end else if (enable_pp) begin
                dp_cnt   <= dp_cnt + 5'd1;
                dp_count <= (dp_cnt == 5'd15);
            end
            if (enable_pp) begin
                {dp_acc, dp_q, dp_qm1} <= booth_step(dp_acc, dp_q, dp_qm1, dp_m);
            end else begin
                if (load_pp) begin
                    dp_acc <= '0;
                    dp_qm1 <= 1'b0;
                end
                if (enable_b) dp_q <= op_b;
            end
            if (load_p) dp_product <= {dp_acc[15:0], dp_q};
        end
    end

    function automatic logic [31:0] ref_product(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called and returns on a falling edge; inputs change only there.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                          input bit exp_abort, input bit keep_valid, input bit exp_stale);
        int waited = 0;
        int lat = 0;
        int n_ld = 0, n_pp = 0, n_lp = 0, n_mult = 0, n_overlap = 0;
        bit done = 1'b0;
        logic [31:0] want;
        want = ref_product(a, b);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_wait", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (keep_valid) check("b2b_accept_wait", waited, 0);
        if (exp_stale) check("stale_count_at_accept", {31'b0, count}, 32'd1);
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("load_phase", {26'b0, load, load_pp, enable_a, enable_b, busy, error},
                      32'b111110);
                if (!keep_valid) in_valid = 1'b0;
            end
            n_ld += int'(load);
            n_pp += int'(enable_pp);
            n_lp += int'(load_p);
            if (busy && !load && !load_p && !out_valid) n_mult++;
            if ($countones({load, enable_pp, load_p, out_valid}) > 1) n_overlap++;
            done = out_valid || (lat > 1 && in_ready);
        end
        check("strobe_overlap", n_overlap, 0);
        if (exp_abort) begin
            check("abort_mult_cycles", n_mult, TIMEOUT);
            check("abort_pp_pulses", n_pp, TIMEOUT);
            check("abort_no_valid", {31'b0, out_valid}, 32'd0);
            check("abort_error", {31'b0, error}, 32'd1);
            check("abort_idle", {31'b0, in_ready}, 32'd1);
        end else begin
            check("latency", lat, LATENCY);
            check("load_pulses", n_ld, 1);
            check("pp_pulses", n_pp, STEPS);
            check("load_p_pulses", n_lp, 1);
            check("product", dp_product, want);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_product", dp_product, want);
                check("hold_no_accept", {31'b0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("idle_after_ready", {29'b0, in_ready, busy, out_valid}, 32'b100);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {22'b0, in_ready, busy, out_valid, load, load_pp, enable_a, enable_b,
               enable_pp, load_p, error}, 32'b1000000000);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and signed operations; the second sees count left high by the first.
        run_op(16'd3, 16'd5, 0, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFF9, 16'd6, 5, 1'b0, 1'b0, 1'b1);

        // Watchdog abort, sticky error, then cleared by the next request.
        stuck0 = 1'b1;
        run_op(16'd1234, 16'd77, 0, 1'b1, 1'b0, 1'b0);
        stuck0 = 1'b0;
        repeat (3) @(negedge clk);
        check("error_sticky", {30'b0, error, busy}, 32'b10);
        run_op(16'd100, 16'hFFFD, 1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the eighth MULT cycle.
        op_a = 16'h1111;
        op_b = 16'h2222;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mult8_busy", {30'b0, busy, enable_pp}, 32'b11);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs",
                 {24'b0, in_ready, busy, out_valid, load, load_pp, enable_pp, load_p, error},
                 32'b10000000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'b0, in_ready}, 32'd1);
        run_op(16'h8000, 16'h8000, 0, 1'b0, 1'b0, 1'b0);

        // Back-to-back with in_valid held high throughout.
        for (int i = 0; i < 4; i++) begin
            run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Randomized operands and consumer stalls.
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b1);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
